// File: rtl/des_block_serializer.sv
// Block-to-byte output stage after the DES final permutation.
// It buffers 64-bit ciphertext blocks in a small FIFO and streams each one out as 8 bytes.
module des_block_serializer #(
  parameter int DEPTH     = 2,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] blk_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    byte_idx;
  logic          push;
  logic          byte_xfer;
  logic          pop;
  logic [2:0]    sel;
  logic [63:0]   head;

  // Handshakes depend only on registered state, gated off while reset is asserted.
  assign in_ready  = rst_n && (count < CW'(DEPTH));
  assign out_valid = rst_n && (count != '0);
  assign out_last  = out_valid && (byte_idx == 3'd7);

  assign push      = in_valid && in_ready;
  assign byte_xfer = out_valid && out_ready;
  assign pop       = byte_xfer && (byte_idx == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      byte_idx  <= '0;
      blk_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (byte_xfer)
        byte_idx <= byte_idx + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        blk_count <= blk_count + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; push is already suppressed during reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_comb begin
    head     = mem[rd_ptr];
    sel      = MSB_FIRST ? (3'd7 - byte_idx) : byte_idx;
    out_data = 8'h00;
    if (out_valid)
      out_data = head[{sel, 3'b000} +: 8];
  end

endmodule

// File: tb/tb_des_block_serializer.sv
// Bench for des_block_serializer: one MSB-first and one LSB-first instance, with a byte scoreboard for each.
module tb_des_block_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] m_in_data, l_in_data;
  logic        m_in_valid, l_in_valid, m_in_ready, l_in_ready;
  logic [7:0]  m_out_data, l_out_data;
  logic        m_out_valid, l_out_valid, m_out_ready, l_out_ready;
  logic        m_out_last, l_out_last;
  logic [15:0] m_blk_count, l_blk_count;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [8:0]  q_m[$];
  logic [8:0]  q_l[$];
  logic        m_hold = 1'b0, l_hold = 1'b0;
  logic [7:0]  m_prev_data, l_prev_data;
  logic        m_prev_last, l_prev_last;

  always #5 clk = ~clk;

  des_block_serializer #(.DEPTH(2), .MSB_FIRST(1'b1), .CNT_W(16)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_data(m_in_data), .in_valid(m_in_valid),
    .in_ready(m_in_ready), .out_data(m_out_data), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .out_last(m_out_last), .blk_count(m_blk_count)
  );

  des_block_serializer #(.DEPTH(2), .MSB_FIRST(1'b0), .CNT_W(16)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_data(l_in_data), .in_valid(l_in_valid),
    .in_ready(l_in_ready), .out_data(l_out_data), .out_valid(l_out_valid),
    .out_ready(l_out_ready), .out_last(l_out_last), .blk_count(l_blk_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] expected_byte(input logic [63:0] blk, input int k, input bit msb);
    return msb ? blk[63-8*k -: 8] : blk[8*k +: 8];
  endfunction

  task automatic push_block(input bit sel_l, input logic [63:0] blk);
    for (int k = 0; k < 8; k++) begin
      if (sel_l) q_l.push_back({k == 7, expected_byte(blk, k, 1'b0)});
      else       q_m.push_back({k == 7, expected_byte(blk, k, 1'b1)});
    end
  endtask

  // Offers a block, waits (bounded) for in_ready, records its bytes, then returns 1ns after the accept edge.
  task automatic applyStimulus(input bit sel_l, input logic [63:0] blk);
    bit ok = 1'b0;
    if (sel_l) begin l_in_data = blk; l_in_valid = 1'b1; end
    else       begin m_in_data = blk; m_in_valid = 1'b1; end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sel_l ? l_in_ready : m_in_ready) begin ok = 1'b1; break; end
    end
    checkOutput("accept_in_time", 64'(ok), 64'd1);
    if (ok) push_block(sel_l, blk);
    @(posedge clk); #1;
    if (sel_l) l_in_valid = 1'b0;
    else       m_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input bit sel_l);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sel_l ? (q_l.size() == 0 && !l_out_valid) : (q_m.size() == 0 && !m_out_valid)) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("drain_in_time", 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q_m.delete();
    q_l.delete();
  endtask

  // Scoreboard and hold-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (m_hold && m_out_valid) begin
      checkOutput("m_hold_data", m_out_data, m_prev_data);
      checkOutput("m_hold_last", m_out_last, m_prev_last);
    end
    if (m_out_valid && m_out_ready) begin
      checkOutput("m_byte_expected", 64'(q_m.size() != 0), 64'd1);
      if (q_m.size() != 0) begin
        e = q_m.pop_front();
        checkOutput("m_byte", m_out_data, e[7:0]);
        checkOutput("m_last", m_out_last, e[8]);
      end
    end
    m_hold = m_out_valid && !m_out_ready;
    m_prev_data = m_out_data;
    m_prev_last = m_out_last;

    if (l_hold && l_out_valid) begin
      checkOutput("l_hold_data", l_out_data, l_prev_data);
      checkOutput("l_hold_last", l_out_last, l_prev_last);
    end
    if (l_out_valid && l_out_ready) begin
      checkOutput("l_byte_expected", 64'(q_l.size() != 0), 64'd1);
      if (q_l.size() != 0) begin
        e = q_l.pop_front();
        checkOutput("l_byte", l_out_data, e[7:0]);
        checkOutput("l_last", l_out_last, e[8]);
      end
    end
    l_hold = l_out_valid && !l_out_ready;
    l_prev_data = l_out_data;
    l_prev_last = l_out_last;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at time %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] blk_a, blk_b, blk_c;

    // Reset held 3 cycles with an all-ones block offered.
    rst_n = 1'b0;
    m_in_valid = 1'b1; m_in_data = 64'hFFFF_FFFF_FFFF_FFFF; m_out_ready = 1'b0;
    l_in_valid = 1'b0; l_in_data = '0; l_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_in_ready", m_in_ready, 1'b0);
      checkOutput("rst_out_valid", m_out_valid, 1'b0);
      checkOutput("rst_out_data", m_out_data, 8'h00);
      checkOutput("rst_out_last", m_out_last, 1'b0);
      checkOutput("rst_blk_count", m_blk_count, 16'd0);
      checkOutput("rst_l_in_ready", l_in_ready, 1'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_rst_out_valid", m_out_valid, 1'b0);
      checkOutput("post_rst_in_ready", m_in_ready, 1'b1);
    end
    @(posedge clk); #1;

    // Single block, MSB first, no backpressure: 8 consecutive bytes one cycle after accept.
    m_out_ready = 1'b1;
    applyStimulus(1'b0, 64'h0123_4567_89AB_CDEF);
    checkOutput("single_blk_before", m_blk_count, 16'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("single_valid_run", m_out_valid, 1'b1);
    end
    @(negedge clk);
    checkOutput("single_valid_after", m_out_valid, 1'b0);
    checkOutput("single_blk_after", m_blk_count, 16'd1);
    @(posedge clk); #1;

    // LSB first with out_ready alternating 0/1: 16 cycles to drain.
    applyStimulus(1'b1, 64'h0123_4567_89AB_CDEF);
    for (int c = 0; c < 16; c++) begin
      l_out_ready = c[0];
      if (c == 15) begin
        checkOutput("bp_last_cycle_valid", l_out_valid, 1'b1);
        checkOutput("bp_last_cycle_last", l_out_last, 1'b1);
      end
      @(posedge clk); #1;
    end
    l_out_ready = 1'b0;
    checkOutput("bp_drained_valid", l_out_valid, 1'b0);
    checkOutput("bp_blk_count", l_blk_count, 16'd1);
    checkOutput("bp_sb_empty", 64'(q_l.size()), 64'd0);

    // Full buffer: A and B accepted, C held until A's 8th byte has popped.
    reset_pulse();
    blk_a = 64'h1111_1111_1111_1111;
    blk_b = 64'h2222_2222_2222_2222;
    blk_c = 64'h3333_3333_3333_3333;
    m_out_ready = 1'b0;
    applyStimulus(1'b0, blk_a);
    applyStimulus(1'b0, blk_b);
    m_in_data = blk_c;
    m_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("full_in_ready", m_in_ready, 1'b0);
      @(posedge clk); #1;
    end
    m_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checkOutput("full_drain_a_in_ready", m_in_ready, 1'b0);
      @(posedge clk); #1;
    end
    checkOutput("full_slot_freed", m_in_ready, 1'b1);
    push_block(1'b0, blk_c);
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    wait_drain(1'b0);
    checkOutput("full_blk_count", m_blk_count, 16'd3);

    // Accept on the same edge as the head block's last byte: count stays at 1.
    reset_pulse();
    m_out_ready = 1'b1;
    applyStimulus(1'b0, blk_a);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("simul_pre_last", m_out_last, 1'b1);
    checkOutput("simul_pre_in_ready", m_in_ready, 1'b1);
    m_in_data = blk_b;
    m_in_valid = 1'b1;
    push_block(1'b0, blk_b);
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    checkOutput("simul_out_valid", m_out_valid, 1'b1);
    checkOutput("simul_in_ready", m_in_ready, 1'b1);
    checkOutput("simul_blk_count", m_blk_count, 16'd1);
    wait_drain(1'b0);
    checkOutput("simul_blk_final", m_blk_count, 16'd2);

    // Reset after 3 bytes discards the partial block.
    applyStimulus(1'b0, 64'hDEAD_BEEF_CAFE_F00D);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    q_m.delete();
    @(negedge clk);
    checkOutput("midrst_out_valid", m_out_valid, 1'b0);
    checkOutput("midrst_out_data", m_out_data, 8'h00);
    @(posedge clk); #1;
    checkOutput("midrst_blk_count", m_blk_count, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_empty_after", m_out_valid, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 64'h0011_2233_4455_6677);
    checkOutput("midrst_first_byte", m_out_data, 8'h00);
    wait_drain(1'b0);
    checkOutput("midrst_blk_final", m_blk_count, 16'd1);
    checkOutput("final_sb_m_empty", 64'(q_m.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
